// File: rtl/ram_port0_responder.sv
// RAM port-0 responder: 1RW nibble-masked word memory with a 1..4 cycle read
// pipeline, out-of-range error pulse and saturating read/write counters.
//
// Ports:
//   clk0, rst0 (async, active high)
//   cs0, we0, wmask0, addr0, din0 : access sampled on the rising edge of clk0
//   dout0, dout0_vld              : read data and its one-cycle valid pulse
//   err0                          : one-cycle pulse for addr0 >= DEPTH
//   rd_cnt, wr_cnt                : accepted reads/writes since reset
//
// Optional macro RAM_PORT0_WRITE_THROUGH_EN: in-range writes also push the
// merged post-write word through the read pipeline (rd_cnt unaffected).
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 8
`endif

module ram_port0_responder #(
  parameter int DATA_WIDTH   = `DATA_WIDTH,
  parameter int ADDR_WIDTH   = `ADDR_WIDTH,
  parameter int DEPTH        = 2 ** ADDR_WIDTH,
  parameter int READ_LATENCY = 1
) (
  input  logic                    clk0,
  input  logic                    rst0,
  input  logic                    cs0,
  input  logic                    we0,
  input  logic [DATA_WIDTH/4-1:0] wmask0,
  input  logic [ADDR_WIDTH-1:0]   addr0,
  input  logic [DATA_WIDTH-1:0]   din0,
  output logic [DATA_WIDTH-1:0]   dout0,
  output logic                    dout0_vld,
  output logic                    err0,
  output logic [15:0]             rd_cnt,
  output logic [15:0]             wr_cnt
);

  localparam int NW = DATA_WIDTH / 4;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic meta;
  logic live;
  logic ok;
  logic acc;
  logic rd_acc;
  logic wr_acc;
  logic inr;
  logic [DATA_WIDTH-1:0] cur;
  logic [DATA_WIDTH-1:0] merged;
  logic                  inj_v;
  logic [DATA_WIDTH-1:0] inj_d;
  logic                  tap_v;
  logic [DATA_WIDTH-1:0] tap_d;

  // Two-flop release synchronizer. meta is the D input of live, so
  // accepting on (meta | live) starts honouring accesses on the second
  // rising edge after rst0 falls and stays on once live is set.
  always_ff @(posedge clk0 or posedge rst0) begin
    if (rst0) begin
      meta <= 1'b0;
      live <= 1'b0;
    end else begin
      meta <= 1'b1;
      live <= meta;
    end
  end

  assign ok     = meta | live;
  assign acc    = cs0 & ok;
  assign rd_acc = acc & ~we0;
  assign wr_acc = acc & we0;
  assign inr    = {1'b0, addr0} < (ADDR_WIDTH + 1)'(DEPTH);
  assign cur    = inr ? mem[addr0] : '0;

  always_comb begin
    merged = cur;
    for (int i = 0; i < NW; i++) begin
      if (wmask0[i]) merged[4*i +: 4] = din0[4*i +: 4];
    end
  end

  always_ff @(posedge clk0) begin
    if (wr_acc && inr) mem[addr0] <= merged;
  end

`ifdef RAM_PORT0_WRITE_THROUGH_EN
  assign inj_v = rd_acc | (wr_acc & inr);
  assign inj_d = we0 ? merged : cur;
`else
  assign inj_v = rd_acc;
  assign inj_d = cur;
`endif

  // Output register is the last pipeline stage; READ_LATENCY-1 extra
  // stages sit in front of it.
  if (READ_LATENCY == 1) begin : g_direct
    assign tap_v = inj_v;
    assign tap_d = inj_d;
  end else begin : g_pipe
    localparam int S = READ_LATENCY - 1;
    logic [S-1:0]          pv;
    logic [DATA_WIDTH-1:0] pd [S];

    always_ff @(posedge clk0 or posedge rst0) begin
      if (rst0) begin
        pv <= '0;
      end else begin
        pv[0] <= inj_v;
        for (int i = 1; i < S; i++) pv[i] <= pv[i-1];
      end
    end

    always_ff @(posedge clk0) begin
      pd[0] <= inj_d;
      for (int i = 1; i < S; i++) pd[i] <= pd[i-1];
    end

    assign tap_v = pv[S-1];
    assign tap_d = pd[S-1];
  end

  always_ff @(posedge clk0 or posedge rst0) begin
    if (rst0) begin
      dout0     <= '0;
      dout0_vld <= 1'b0;
      err0      <= 1'b0;
      rd_cnt    <= '0;
      wr_cnt    <= '0;
    end else begin
      dout0_vld <= tap_v;
      if (tap_v) dout0 <= tap_d;
      err0 <= acc & ~inr;
      if (rd_acc && rd_cnt != 16'hFFFF) rd_cnt <= rd_cnt + 16'd1;
      if (wr_acc && wr_cnt != 16'hFFFF) wr_cnt <= wr_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_ram_port0_responder.sv
// Directed bench for ram_port0_responder: four instances (READ_LATENCY 1..4,
// DEPTH=200) share one stimulus stream; expectations are hand-computed.
`timescale 1ns/1ps

module tb_ram_port0_responder;

  logic        clk0 = 1'b0;
  logic        rst0 = 1'b0;
  logic        cs0 = 1'b0;
  logic        we0 = 1'b0;
  logic [7:0]  wmask0 = '0;
  logic [7:0]  addr0 = '0;
  logic [31:0] din0 = '0;

  logic [31:0] dout [4];
  logic        vld [4];
  logic        err [4];
  logic [15:0] rc [4];
  logic [15:0] wc [4];

  int total = 0;
  int bad = 0;
  int erd = 0;
  int ewr = 0;

  logic        sv [4][8];
  logic [31:0] sd [4][8];

  always #5 clk0 = ~clk0;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    ram_port0_responder #(
      .DATA_WIDTH(32), .ADDR_WIDTH(8),
      .DEPTH(200), .READ_LATENCY(g + 1)
    ) u_dut (
      .clk0(clk0), .rst0(rst0), .cs0(cs0),
      .we0(we0), .wmask0(wmask0), .addr0(addr0),
      .din0(din0), .dout0(dout[g]),
      .dout0_vld(vld[g]), .err0(err[g]),
      .rd_cnt(rc[g]), .wr_cnt(wc[g])
    );
  end

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk0);
    #1;
  endtask

  task automatic idle();
    cs0 = 1'b0;
    we0 = 1'b0;
    step();
  endtask

  task automatic wr(logic [7:0] a, logic [31:0] d, logic [7:0] m);
    cs0 = 1'b1; we0 = 1'b1;
    addr0 = a; din0 = d; wmask0 = m;
    ewr++;
    step();
    cs0 = 1'b0; we0 = 1'b0;
  endtask

  task automatic rd(logic [7:0] a);
    cs0 = 1'b1; we0 = 1'b0;
    addr0 = a; wmask0 = '0;
    erd++;
    step();
    cs0 = 1'b0;
  endtask

  task automatic cnts(string tag);
    for (int d = 0; d < 4; d++) begin
      chk($sformatf("%s_rc%0d", tag, d + 1), 32'(rc[d]), 32'(erd));
      chk($sformatf("%s_wc%0d", tag, d + 1), 32'(wc[d]), 32'(ewr));
    end
  endtask

  // Called just after the edge that sampled one pipeline-producing access.
  task automatic seq_check(string tag, logic [31:0] e);
    for (int k = 0; k < 5; k++) begin
      for (int d = 0; d < 4; d++) begin
        chk($sformatf("%s_v%0d_k%0d", tag, d + 1, k),
            32'(vld[d]), 32'(k == d));
        if (k == d)
          chk($sformatf("%s_d%0d", tag, d + 1), dout[d], e);
      end
      if (k < 4) idle();
    end
  endtask

  task automatic no_vld(string tag, int n);
    for (int k = 0; k < n; k++) begin
      for (int d = 0; d < 4; d++)
        chk($sformatf("%s_v%0d_k%0d", tag, d + 1, k), 32'(vld[d]), 32'd0);
      idle();
    end
  endtask

  initial begin
    // Reset then idle
    #2 rst0 = 1'b1;
    #10 rst0 = 1'b0;
    for (int c = 0; c < 10; c++) begin
      idle();
      for (int d = 0; d < 4; d++) begin
        chk($sformatf("idle_v%0d", d + 1), 32'(vld[d]), 32'd0);
        chk($sformatf("idle_d%0d", d + 1), dout[d], 32'd0);
        chk($sformatf("idle_e%0d", d + 1), 32'(err[d]), 32'd0);
      end
      cnts("idle");
    end

    // Masked write and readback
    wr(8'h10, 32'hDEADBEEF, 8'hFF);
    wr(8'h10, 32'h12345678, 8'h0F);
    cnts("mwr");
    for (int c = 0; c < 5; c++) idle();
    rd(8'h10);
    seq_check("mrd", 32'hDEAD5678);
    cnts("mrd");

    // Latency sweep: preload, then four back-to-back reads
    for (int a = 0; a < 4; a++)
      wr(8'(a), 32'hA0 + 32'(a), 8'hFF);
    wr(8'd199, 32'h0000_0199, 8'hFF);
    for (int c = 0; c < 5; c++) idle();
    for (int k = 0; k < 8; k++) begin
      if (k < 4) rd(8'(k));
      else idle();
      for (int d = 0; d < 4; d++) begin
        sv[d][k] = vld[d];
        sd[d][k] = dout[d];
      end
    end
    for (int d = 0; d < 4; d++) begin
      for (int k = 0; k < 8; k++) begin
        chk($sformatf("sweep_v%0d_k%0d", d + 1, k), 32'(sv[d][k]),
            32'(k >= d && k <= d + 3));
        if (k >= d && k <= d + 3)
          chk($sformatf("sweep_d%0d_k%0d", d + 1, k), sd[d][k],
              32'hA0 + 32'(k - d));
      end
    end
    cnts("sweep");

    // Out of range
    wr(8'd200, 32'hFFFFFFFF, 8'hFF);
    for (int d = 0; d < 4; d++)
      chk($sformatf("oorw_e%0d", d + 1), 32'(err[d]), 32'd1);
    cnts("oorw");
    idle();
    for (int d = 0; d < 4; d++)
      chk($sformatf("oorw_e%0d_off", d + 1), 32'(err[d]), 32'd0);
    no_vld("oorw", 4);
    rd(8'd200);
    for (int d = 0; d < 4; d++)
      chk($sformatf("oorr_e%0d", d + 1), 32'(err[d]), 32'd1);
    seq_check("oorr", 32'h0);
    rd(8'd199);
    for (int d = 0; d < 4; d++)
      chk($sformatf("r199_e%0d", d + 1), 32'(err[d]), 32'd0);
    seq_check("r199", 32'h0000_0199);
    cnts("oor");

    // Write-through
    wr(8'h05, 32'hFFFFFFFF, 8'hFF);
    for (int c = 0; c < 5; c++) idle();
    wr(8'h05, 32'h0000CAFE, 8'h0F);
`ifdef RAM_PORT0_WRITE_THROUGH_EN
    seq_check("wt", 32'hFFFFCAFE);
`else
    no_vld("wt", 5);
`endif
    cnts("wt");
    for (int c = 0; c < 3; c++) idle();
    rd(8'h05);
    seq_check("wtrd", 32'hFFFFCAFE);

    // Reset mid-read (READ_LATENCY=3 instance is the critical one)
    for (int c = 0; c < 3; c++) idle();
    rd(8'h10);
    idle();
    rst0 = 1'b1;
    erd = 0;
    ewr = 0;
    #2;
    idle();
    for (int d = 0; d < 4; d++) begin
      chk($sformatf("rst_v%0d", d + 1), 32'(vld[d]), 32'd0);
      chk($sformatf("rst_d%0d", d + 1), dout[d], 32'd0);
    end
    cnts("rst");
    rst0 = 1'b0;
    no_vld("post", 6);
    cnts("post");
    rd(8'h10);
    seq_check("keep", 32'hDEAD5678);
    cnts("keep");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=%0d exp=%0d", total, 0);
    $fatal(1, "timeout");
  end

endmodule
